br_track_queue: RTL and testbench

BR_TRACK_QUEUE -- requirements
Module: br_track_queue

---
 rtl/br_track_queue_pkg.sv | 39 +++
 rtl/br_track_queue_if.sv | 58 +++++
 rtl/br_track_queue_br_rob_cam.sv | 53 +++++
 rtl/br_track_queue.sv | 185 ++++++++++++++++++
 tb/tb_br_track_queue.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_track_queue_pkg.sv
// Shared branch-tracking types: instruction class, queue entry layout and
// the small helpers both the queue and its bench rely on.
package br_track_queue_pkg;

    localparam int AddrWidth    = 32;
    localparam int RobDepth     = 64;
    localparam int PredMaxDepth = 8;
    localparam int RobWidth     = $clog2(RobDepth);

    // Encoding of a "taken" direction bit.
    localparam logic BrTaken = 1'b1;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_BRANCH = 3'd1,
        BR_JUMP   = 3'd2,
        BR_CALL   = 3'd3,
        BR_RET    = 3'd4
    } BrInstType_t;

    typedef struct packed {
        logic                  valid;
        logic                  resolved;
        logic                  miss;
        BrInstType_t           br_type;
        logic [RobWidth-1:0]   rob_id;
        logic [AddrWidth-1:0]  pc;
        logic                  pred_taken;
        logic [AddrWidth-1:0]  pred_addr;
        logic                  act_taken;
        logic [AddrWidth-1:0]  act_addr;
    } BrTrackEnt_t;

    // Unconditional control transfers (always redirect to the resolved target).
    function automatic logic is_jump(input BrInstType_t t);
        return (t == BR_JUMP) || (t == BR_CALL) || (t == BR_RET);
    endfunction

endpackage

// File: rtl/br_track_queue_if.sv
// Decode / execute / commit signal bundle of the branch tracking queue.
// Handshake: every *_e_ strobe is active-low and is acted on at the rising
// clock edge where it is sampled low; there is no back-pressure other than
// enq_full, and all result pulses (res_miss_, *_commit_) are low for exactly
// one cycle, the cycle after the triggering strobe.
interface br_track_queue_if #(
    parameter int ADDR = 32,
    parameter int ROB  = 6,
    parameter int ID   = 3
);
    import br_track_queue_pkg::*;

    logic            flush_;
    logic            enq_e_;
    BrInstType_t     enq_type;
    logic [ROB-1:0]  enq_rob_id;
    logic [ADDR-1:0] enq_pc;
    logic [ADDR-1:0] enq_pred_addr;
    logic            enq_pred_taken;
    logic            enq_full;
    logic [ID:0]     count;
    logic            res_e_;
    logic [ROB-1:0]  res_rob_id;
    logic            res_taken;
    logic [ADDR-1:0] res_addr;
    logic            res_miss_;
    logic [ADDR-1:0] res_redirect_addr;
    logic            commit_e_;
    logic [ROB-1:0]  com_rob_id;
    logic            br_commit_;
    logic            br_result;
    logic            br_pred_miss_;
    logic            jump_commit_;
    logic            jump_call_;
    logic            jump_return_;
    logic            jump_miss_;
    logic [ADDR-1:0] com_tar_addr;
    logic            err;

    modport master (
        output flush_, enq_e_, enq_type, enq_rob_id, enq_pc, enq_pred_addr,
               enq_pred_taken, res_e_, res_rob_id, res_taken, res_addr,
               commit_e_, com_rob_id,
        input  enq_full, count, res_miss_, res_redirect_addr, br_commit_,
               br_result, br_pred_miss_, jump_commit_, jump_call_,
               jump_return_, jump_miss_, com_tar_addr, err
    );

    modport slave (
        input  flush_, enq_e_, enq_type, enq_rob_id, enq_pc, enq_pred_addr,
               enq_pred_taken, res_e_, res_rob_id, res_taken, res_addr,
               commit_e_, com_rob_id,
        output enq_full, count, res_miss_, res_redirect_addr, br_commit_,
               br_result, br_pred_miss_, jump_commit_, jump_call_,
               jump_return_, jump_miss_, com_tar_addr, err
    );

endinterface

// File: rtl/br_track_queue_br_rob_cam.sv
// DEPTH-way ROB-id match over the queue slots. Reports the one-hot hit
// vector, the oldest hit (first hit walking forward from head) and whether
// more than one slot matched.
module br_rob_cam
    import br_track_queue_pkg::*;
#(
    parameter int DEPTH = PredMaxDepth,
    parameter int ROB   = RobWidth,
    parameter int ID    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]          cand,
    input  logic [DEPTH-1:0][ROB-1:0] ids,
    input  logic [ROB-1:0]            key,
    input  logic [ID-1:0]             head,
    output logic [DEPTH-1:0]          hit,
    output logic                      any,
    output logic                      multi,
    output logic [ID-1:0]             sel
);

    logic          found;
    logic [ID-1:0] idx;

    // Parallel compare of every candidate slot against the key.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = cand[i] && (ids[i] == key);
        end
    end

    assign any = |hit;

    // Oldest-first select: slot index wraps naturally because DEPTH is a power of two.
    always_comb begin
        sel   = '0;
        multi = 1'b0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + ID'(k);
            if (hit[idx]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/br_track_queue.sv
// In-flight branch tracking queue: entries are allocated at decode, resolved
// out of order at execute (early mispredict redirect) and retired in order at
// commit. Entries use the shared BrTrackEnt_t layout, so ADDR and ROB_DEPTH
// are expected to match the package widths.
module br_track_queue
    import br_track_queue_pkg::*;
#(
    parameter int ADDR      = AddrWidth,
    parameter int ROB_DEPTH = RobDepth,
    parameter int DEPTH     = PredMaxDepth
) (
    input  logic           clk,
    input  logic           reset,
    br_track_queue_if.slave bus
);

    localparam int ROB = $clog2(ROB_DEPTH);
    localparam int ID  = $clog2(DEPTH);

    BrTrackEnt_t     ent [DEPTH];
    logic [ID-1:0]   head;
    logic [ID-1:0]   tail;
    logic [ID:0]     cnt;

    logic [DEPTH-1:0]          cam_cand;
    logic [DEPTH-1:0][ROB-1:0] cam_ids;
    logic [DEPTH-1:0]          cam_hit;
    logic                      cam_any;
    logic                      cam_multi;
    logic [ID-1:0]             cam_sel;

    BrTrackEnt_t     r_ent;
    BrTrackEnt_t     h_ent;
    BrTrackEnt_t     new_ent;
    logic            full;
    logic            do_enq;
    logic            do_deq;
    logic            res_act;
    logic            r_jump;
    logic            r_miss;
    logic [ADDR-1:0] r_redirect;
    logic            bypass;
    logic            c_jump;
    logic            c_resolved;
    logic            c_taken;
    logic [ADDR-1:0] c_addr;
    logic            c_report_miss;
    logic [ADDR-1:0] c_tar;

    // Only valid, still-unresolved slots take part in the resolve match.
    always_comb begin
        cam_cand = '0;
        cam_ids  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cam_cand[i] = ent[i].valid && !ent[i].resolved;
            cam_ids[i]  = ent[i].rob_id;
        end
    end

    br_rob_cam #(.DEPTH(DEPTH), .ROB(ROB), .ID(ID)) u_cam (
        .cand  (cam_cand),
        .ids   (cam_ids),
        .key   (bus.res_rob_id),
        .head  (head),
        .hit   (cam_hit),
        .any   (cam_any),
        .multi (cam_multi),
        .sel   (cam_sel)
    );

    // Resolve, commit (with same-cycle resolve bypass) and enqueue decisions.
    always_comb begin
        full    = (cnt == (ID+1)'(DEPTH));
        do_enq  = !bus.enq_e_ && (bus.enq_type != BR_NONE) && !full && bus.flush_;
        new_ent = '{valid: 1'b1, resolved: 1'b0, miss: 1'b0, br_type: bus.enq_type,
                    rob_id: bus.enq_rob_id, pc: bus.enq_pc,
                    pred_taken: bus.enq_pred_taken, pred_addr: bus.enq_pred_addr,
                    act_taken: 1'b0, act_addr: '0};

        // A flush drops the resolve entirely, including its bypass to commit.
        res_act = !bus.res_e_ && bus.flush_ && cam_any;
        r_ent   = ent[cam_sel];
        r_jump  = is_jump(r_ent.br_type);
        if (r_jump) begin
            r_miss = (bus.res_addr != r_ent.pred_addr);
        end else begin
            r_miss = (bus.res_taken != r_ent.pred_taken) ||
                     ((bus.res_taken == BrTaken) && (bus.res_addr != r_ent.pred_addr));
        end
        r_redirect = ((bus.res_taken == BrTaken) || r_jump) ? bus.res_addr
                                                             : r_ent.pc + ADDR'(4);

        h_ent      = ent[head];
        do_deq     = !bus.commit_e_ && h_ent.valid && (h_ent.rob_id == bus.com_rob_id);
        bypass     = res_act && cam_hit[head];
        c_jump     = is_jump(h_ent.br_type);
        c_resolved = h_ent.resolved || bypass;
        c_taken    = bypass ? bus.res_taken : h_ent.act_taken;
        c_addr     = bypass ? bus.res_addr  : h_ent.act_addr;
        // A commit that never saw a resolve is reported as a mispredict.
        c_report_miss = (bypass ? r_miss : h_ent.miss) || !c_resolved;
        c_tar      = ((c_taken == BrTaken) || c_jump) ? c_addr : h_ent.pc + ADDR'(4);
    end

    // Entry storage and head/tail/count bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (!bus.flush_) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (res_act) begin
                ent[cam_sel].resolved  <= 1'b1;
                ent[cam_sel].act_taken <= bus.res_taken;
                ent[cam_sel].act_addr  <= bus.res_addr;
                ent[cam_sel].miss      <= r_miss;
            end
            if (do_deq) begin
                ent[head].valid <= 1'b0;
                head            <= head + 1'b1;
            end
            if (do_enq) begin
                ent[tail] <= new_ent;
                tail      <= tail + 1'b1;
            end
            cnt <= cnt + (ID+1)'(do_enq) - (ID+1)'(do_deq);
        end
    end

    // Registered result pulses, commit reporting and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.res_miss_         <= 1'b1;
            bus.res_redirect_addr <= '0;
            bus.br_commit_        <= 1'b1;
            bus.br_result         <= 1'b0;
            bus.br_pred_miss_     <= 1'b1;
            bus.jump_commit_      <= 1'b1;
            bus.jump_call_        <= 1'b1;
            bus.jump_return_      <= 1'b1;
            bus.jump_miss_        <= 1'b1;
            bus.com_tar_addr      <= '0;
            bus.err               <= 1'b0;
        end else begin
            bus.res_miss_     <= !(res_act && r_miss);
            bus.br_commit_    <= 1'b1;
            bus.br_pred_miss_ <= 1'b1;
            bus.jump_commit_  <= 1'b1;
            bus.jump_call_    <= 1'b1;
            bus.jump_return_  <= 1'b1;
            bus.jump_miss_    <= 1'b1;
            if (res_act && r_miss) begin
                bus.res_redirect_addr <= r_redirect;
            end
            if (do_deq) begin
                bus.com_tar_addr <= c_tar;
                if (c_jump) begin
                    bus.jump_commit_ <= 1'b0;
                    bus.jump_call_   <= !(h_ent.br_type == BR_CALL);
                    bus.jump_return_ <= !(h_ent.br_type == BR_RET);
                    bus.jump_miss_   <= !c_report_miss;
                end else begin
                    bus.br_commit_    <= 1'b0;
                    bus.br_result     <= c_taken;
                    bus.br_pred_miss_ <= !c_report_miss;
                end
            end
            bus.err <= bus.err || (do_deq && !c_resolved) || (res_act && cam_multi);
        end
    end

    assign bus.count    = cnt;
    assign bus.enq_full = full;

endmodule

// File: tb/tb_br_track_queue.sv
// Directed bench for the branch tracking queue: hand-computed expectations
// for resolve, commit, wrap, full, flush and asynchronous reset behaviour.
module tb_br_track_queue;
  import br_track_queue_pkg::*;

  logic clk;
  logic reset;
  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  br_track_queue_if #(.ADDR(32), .ROB(6), .ID(3)) bus ();

  br_track_queue #(.ADDR(32), .ROB_DEPTH(64), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus.flush_         = 1'b1;
    bus.enq_e_         = 1'b1;
    bus.enq_type       = BR_NONE;
    bus.enq_rob_id     = '0;
    bus.enq_pc         = '0;
    bus.enq_pred_addr  = '0;
    bus.enq_pred_taken = 1'b0;
    bus.res_e_         = 1'b1;
    bus.res_rob_id     = '0;
    bus.res_taken      = 1'b0;
    bus.res_addr       = '0;
    bus.commit_e_      = 1'b1;
    bus.com_rob_id     = '0;
  endtask

  // advance one cycle; outputs are then sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_enq(input BrInstType_t t, input logic [5:0] rob, input logic [31:0] pc,
                         input logic [31:0] paddr, input logic ptk);
    bus.enq_e_         = 1'b0;
    bus.enq_type       = t;
    bus.enq_rob_id     = rob;
    bus.enq_pc         = pc;
    bus.enq_pred_addr  = paddr;
    bus.enq_pred_taken = ptk;
  endtask

  task automatic set_res(input logic [5:0] rob, input logic tk, input logic [31:0] addr);
    bus.res_e_     = 1'b0;
    bus.res_rob_id = rob;
    bus.res_taken  = tk;
    bus.res_addr   = addr;
  endtask

  task automatic set_com(input logic [5:0] rob);
    bus.commit_e_  = 1'b0;
    bus.com_rob_id = rob;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();

    // reset values
    check("rst_count", bus.count, 0);
    check("rst_full", bus.enq_full, 0);
    check("rst_err", bus.err, 0);
    check("rst_res_miss", bus.res_miss_, 1);
    check("rst_br_commit", bus.br_commit_, 1);
    check("rst_jump_commit", bus.jump_commit_, 1);
    check("rst_br_result", bus.br_result, 0);
    check("rst_tar", bus.com_tar_addr, 0);
    reset = 1'b0;
    tick();

    // correctly predicted taken branch
    set_enq(BR_BRANCH, 6'd1, 32'h1000, 32'h100, 1'b1);
    tick();
    check("b1_count", bus.count, 1);
    set_res(6'd1, 1'b1, 32'h100);
    tick();
    check("b1_res_miss", bus.res_miss_, 1);
    set_com(6'd1);
    tick();
    check("b1_commit", bus.br_commit_, 0);
    check("b1_result", bus.br_result, 1);
    check("b1_pred_miss", bus.br_pred_miss_, 1);
    check("b1_tar", bus.com_tar_addr, 32'h100);
    check("b1_count_after", bus.count, 0);
    tick();
    check("b1_pulse_end", bus.br_commit_, 1);

    // mispredicted jump target
    set_enq(BR_JUMP, 6'd2, 32'h40, 32'h200, 1'b1);
    tick();
    set_res(6'd2, 1'b1, 32'h300);
    tick();
    check("j2_res_miss", bus.res_miss_, 0);
    check("j2_redirect", bus.res_redirect_addr, 32'h300);
    tick();
    check("j2_res_miss_end", bus.res_miss_, 1);
    set_com(6'd2);
    tick();
    check("j2_commit", bus.jump_commit_, 0);
    check("j2_miss", bus.jump_miss_, 0);
    check("j2_call", bus.jump_call_, 1);
    check("j2_tar", bus.com_tar_addr, 32'h300);

    // not-taken branch correctly predicted: fall-through target pc+4
    set_enq(BR_BRANCH, 6'd3, 32'h80, 32'h0, 1'b0);
    tick();
    set_res(6'd3, 1'b0, 32'h999);
    tick();
    check("b3_res_miss", bus.res_miss_, 1);
    set_com(6'd9);
    tick();
    check("b3_wrong_id", bus.br_commit_, 1);
    check("b3_wrong_id_cnt", bus.count, 1);
    set_com(6'd3);
    tick();
    check("b3_result", bus.br_result, 0);
    check("b3_pred_miss", bus.br_pred_miss_, 1);
    check("b3_tar", bus.com_tar_addr, 32'h84);

    // predicted not-taken but taken: early redirect to resolved target
    set_enq(BR_BRANCH, 6'd4, 32'h90, 32'h0, 1'b0);
    tick();
    set_res(6'd4, 1'b1, 32'h500);
    tick();
    check("b4_res_miss", bus.res_miss_, 0);
    check("b4_redirect", bus.res_redirect_addr, 32'h500);
    set_com(6'd4);
    tick();
    check("b4_pred_miss", bus.br_pred_miss_, 0);
    check("b4_result", bus.br_result, 1);
    check("b4_tar", bus.com_tar_addr, 32'h500);

    // call resolved and committed in the same cycle (bypass)
    set_enq(BR_CALL, 6'd5, 32'hA0, 32'h600, 1'b1);
    tick();
    set_res(6'd5, 1'b1, 32'h600);
    set_com(6'd5);
    tick();
    check("c5_commit", bus.jump_commit_, 0);
    check("c5_call", bus.jump_call_, 0);
    check("c5_return", bus.jump_return_, 1);
    check("c5_miss", bus.jump_miss_, 1);
    check("c5_tar", bus.com_tar_addr, 32'h600);
    check("c5_res_miss", bus.res_miss_, 1);
    check("c5_err", bus.err, 0);

    // return committed without ever being resolved
    set_enq(BR_RET, 6'd6, 32'hB0, 32'h700, 1'b1);
    tick();
    set_com(6'd6);
    tick();
    check("r6_commit", bus.jump_commit_, 0);
    check("r6_return", bus.jump_return_, 0);
    check("r6_miss", bus.jump_miss_, 0);
    check("r6_err", bus.err, 1);
    check("r6_count", bus.count, 0);
    tick();
    check("r6_err_sticky", bus.err, 1);

    // fill to full; head/tail start at slot 6, so the fill wraps
    for (int i = 0; i < 8; i++) begin
      set_enq(BR_BRANCH, 6'(10 + i), 32'(32'h1000 + 16 * i), 32'h0, 1'b0);
      exp_q.push_back(32'(32'h1004 + 16 * i));
      tick();
    end
    check("fill_count", bus.count, 8);
    check("fill_full", bus.enq_full, 1);
    set_enq(BR_BRANCH, 6'd18, 32'h5000, 32'h0, 1'b0);
    tick();
    check("ninth_count", bus.count, 8);
    set_com(6'd10);
    set_enq(BR_BRANCH, 6'd19, 32'h6000, 32'h0, 1'b0);
    check("full_deq_count_before", bus.count, 8);
    tick();
    check("full_deq_count", bus.count, 7);
    check("full_deq_commit", bus.br_commit_, 0);
    check("fifo_tar_10", bus.com_tar_addr, exp_q.pop_front());
    for (int i = 1; i < 8; i++) begin
      set_com(6'(10 + i));
      tick();
      check("fifo_commit", bus.br_commit_, 0);
      check("fifo_tar", bus.com_tar_addr, exp_q.pop_front());
    end
    check("drain_count", bus.count, 0);
    check("drain_full", bus.enq_full, 0);
    set_com(6'd19);
    tick();
    check("rejected_absent", bus.br_commit_, 1);

    // second pass across the wrap point with mixed targets
    for (int i = 0; i < 5; i++) begin
      set_enq(BR_BRANCH, 6'(20 + i), 32'(32'h7000 + 8 * i), 32'h0, 1'b0);
      exp_q.push_back(32'(32'h7004 + 8 * i));
      tick();
    end
    check("wrap_count", bus.count, 5);
    for (int i = 0; i < 5; i++) begin
      set_com(6'(20 + i));
      tick();
      check("wrap_tar", bus.com_tar_addr, exp_q.pop_front());
    end
    check("wrap_drain", bus.count, 0);

    // flush with same-cycle commit of head
    set_enq(BR_BRANCH, 6'd30, 32'h2000, 32'h800, 1'b1);
    tick();
    set_enq(BR_BRANCH, 6'd31, 32'h2010, 32'h0, 1'b0);
    tick();
    set_enq(BR_BRANCH, 6'd32, 32'h2020, 32'h0, 1'b0);
    tick();
    set_res(6'd30, 1'b1, 32'h800);
    tick();
    check("fl_count3", bus.count, 3);
    bus.flush_ = 1'b0;
    set_com(6'd30);
    set_res(6'd31, 1'b1, 32'h900);
    set_enq(BR_BRANCH, 6'd33, 32'h2030, 32'h0, 1'b0);
    tick();
    check("fl_commit", bus.br_commit_, 0);
    check("fl_result", bus.br_result, 1);
    check("fl_tar", bus.com_tar_addr, 32'h800);
    check("fl_count", bus.count, 0);
    check("fl_no_res_miss", bus.res_miss_, 1);
    set_res(6'd31, 1'b1, 32'h900);
    tick();
    check("fl_late_res", bus.res_miss_, 1);
    set_com(6'd31);
    tick();
    check("fl_late_com", bus.br_commit_, 1);
    set_enq(BR_BRANCH, 6'd40, 32'h3000, 32'h0, 1'b0);
    tick();
    check("fl_reenq", bus.count, 1);
    set_com(6'd40);
    tick();
    check("fl_recommit", bus.br_commit_, 0);
    check("fl_recommit_tar", bus.com_tar_addr, 32'h3004);

    // asynchronous reset mid-operation with a commit pulse pending
    for (int i = 0; i < 4; i++) begin
      set_enq(BR_BRANCH, 6'(50 + i), 32'(32'h4000 + 16 * i), 32'h0, 1'b0);
      tick();
    end
    check("ar_count4", bus.count, 4);
    set_com(6'd50);
    tick();
    check("ar_pulse", bus.br_commit_, 0);
    #2;
    reset = 1'b1;
    #1;
    check("ar_count", bus.count, 0);
    check("ar_commit", bus.br_commit_, 1);
    check("ar_pred_miss", bus.br_pred_miss_, 1);
    check("ar_err", bus.err, 0);
    check("ar_tar", bus.com_tar_addr, 0);
    check("ar_full", bus.enq_full, 0);
    #1;
    reset = 1'b0;
    set_enq(BR_BRANCH, 6'd60, 32'h8000, 32'h0, 1'b0);
    tick();
    check("ar_first_enq", bus.count, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
